// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a registered one-hot grant and request/done release.
// Optional forced release after MAX_HOLD cycles is built when ARB_TIMEOUT_EN is defined.
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

`ifdef ARB_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [0:0] state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] idx_q, idx_d;
  logic       valid_q, valid_d;
  logic       timeout_q, timeout_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [1:0] last_q, last_d;

  logic       win_found;
  logic [1:0] win_idx;
  logic [1:0] cand;
  logic       release_c;
  logic       force_c;

  // Rotating search: first set request at or after last+1, wrapping 3->0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    cand      = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign release_c = done | ~req[idx_q];
  assign force_c   = TIMEOUT_EN && (hold_cnt_q == HOLD_LAST);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    idx_d      = idx_q;
    valid_d    = valid_q;
    timeout_d  = 1'b0;
    hold_cnt_d = hold_cnt_q;
    last_d     = last_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d    = GRANT;
          idx_d      = win_idx;
          valid_d    = 1'b1;
          gnt_d      = 4'b0001 << win_idx;
          hold_cnt_d = 8'd0;
        end
      end
      GRANT: begin
        // A normal release wins over a simultaneous timeout, so timeout only flags forced drops.
        if (release_c || force_c) begin
          state_d    = IDLE;
          gnt_d      = 4'b0000;
          idx_d      = 2'd0;
          valid_d    = 1'b0;
          last_d     = idx_q;
          timeout_d  = ~release_c;
          hold_cnt_d = 8'd0;
        end else if (hold_cnt_q != 8'hFF) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        idx_d   = 2'd0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= 4'b0000;
      idx_q      <= 2'd0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      hold_cnt_q <= 8'd0;
      last_q     <= 2'd3;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
      hold_cnt_q <= hold_cnt_d;
      last_q     <= last_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;
  assign timeout   = timeout_q;

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter that shares one decoded resource among four clients.
- Internally it selects a 2-bit winner index plus an enable, in the same form as the 2-to-4 decoder's A/en inputs.
- It drives a registered one-hot grant vector equal to the decoder output of that index and enable.
- It sits in front of any shared bus or unit selected through the 2-to-4 decode path, and sequences ownership with a request/done handshake.

Parameters:
- MAX_HOLD, default 8: maximum consecutive cycles one requester may hold the grant. Range 1-255. Used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  input  1: single clock; all state updates on the rising edge.
- rst  input  1: synchronous reset, active-high.
- req  input  4: request lines; bit i is requester i; level-sensitive.
- done  input  1: current owner releases the resource this cycle.
- gnt  output  4: one-hot grant, registered; 4'b0000 when no owner.
- gnt_idx  output  2: binary index of the current owner; valid only when gnt_valid=1.
- gnt_valid  output  1: high while a grant is held; acts as the decoder enable.
- timeout  output  1: one-cycle pulse when a grant is force-released.

Behaviour:
- Reset: rst=1 at a rising edge gives state=IDLE, gnt=4'b0000, gnt_idx=2'b00, gnt_valid=0, timeout=0, hold_cnt=0, last=2'b11. With last=3, requester 0 has top priority after reset.
- Reset is honoured in any state, including mid-grant. The grant drops on the same edge; no done is required.
- States: IDLE and GRANT.
- IDLE behaviour:
  - If req != 0, search starts at (last+1) mod 4 and wraps 3->0; the first set bit wins.
  - On the next edge: gnt_idx=winner, gnt_valid=1, gnt=one-hot(winner), state=GRANT, hold_cnt=0.
  - Latency from req sampled high to gnt high is 1 cycle.
  - If req == 0, remain in IDLE with all outputs at reset values (except last).
- GRANT behaviour:
  - The grant holds while req[gnt_idx]=1 and done=0.
  - Release condition: done=1, or req[gnt_idx]=0. On the next edge: state=IDLE, gnt=0, gnt_valid=0, last=gnt_idx.
  - Exactly one bubble cycle with no grant follows every release. Arbitration for the next owner occurs in that IDLE cycle.
- Output invariants:
  - gnt always equals (gnt_valid ? 4'b0001<<gnt_idx : 4'b0000).
  - gnt is never multi-hot.
- Boundary conditions:
  - done while in IDLE is ignored.
  - done and a req change in the same cycle count as one release; there is no double effect.
  - A requester lowering req mid-grant releases the grant as if done were asserted.
  - Requests from non-owners during GRANT are never granted until release; no preemption.
  - Starvation-free: with all four requesting continuously and each owner releasing, the grant order is 0,1,2,3,0,...
- hold_cnt: 8-bit, increments each cycle in GRANT, saturates at 255, and clears on entry to GRANT.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, if hold_cnt == MAX_HOLD-1 and no release condition is present, force release on the next edge.
  - Forced release behaves like a done release: gnt=0, state=IDLE, last=gnt_idx.
  - timeout=1 for exactly that one cycle, coincident with the first gnt=0 cycle.
  - An owner therefore holds for at most MAX_HOLD cycles.
  - A normal release on the same cycle takes priority, and timeout stays 0.
- Undefined:
  - No forced release; ownership is held indefinitely until done or req drop.
  - timeout is tied to 0.
  - hold_cnt logic may be removed.

Test Plan:
1. rst=1 for 2 cycles, req=4'b1111 during reset: gnt=0000, gnt_valid=0, timeout=0 throughout. On release of reset, gnt=0001 one cycle after the first sampled edge.
2. req=4'b1111 held; pulse done for 1 cycle after each grant (2 cycles): gnt sequence is 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001. gnt_idx is 0,1,2,3,0 on the grant cycles.
3. req=4'b0100 only: gnt=0100, gnt_idx=2 after 1 cycle. Drop req[2] with done=0: gnt=0000 the next cycle, and a subsequent req=4'b0101 grants 0001 (wrap from last=2).
4. Grant held by requester 1 (gnt=0010); assert rst for 1 cycle: gnt=0000 on that edge. After reset, req=4'b0010 grants 0010 again (last reset to 3).
5. done=1 pulsed while IDLE with req=0: no state change, gnt stays 0000. Then req=4'b1000 gives gnt=1000 one cycle later.
6. ARB_TIMEOUT_EN defined, MAX_HOLD=4, req=4'b0011, no done:
   - gnt=0001 for exactly 4 cycles, then gnt=0000 with timeout=1 for 1 cycle, then gnt=0010.
   - Macro undefined: gnt=0001 persists for 20 cycles with timeout=0.
